rv32i_insn_encoder: RTL and testbench

- Inverse of the instruction decoder. Takes RV32I instruction fields (format, opcode, register indices, funct3/funct7, full 32-bit immediate) over a valid/ready stream.
- Packs the fields into a 32-bit instruction word, tags it with an incrementing instruction-memory byte address, and flags immediates that are out of range or misaligned.
- Sits between the bench/program loader and instruction memory. Encoded words round-trip through the decoder and immgen for self-checking.

---
 rtl/rv32i_insn_encoder.sv | 147 ++++++++++++++
 tb/tb_rv32i_insn_encoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_insn_encoder.sv
// RV32I instruction encoder: packs field bundles into 32-bit words over a valid/ready
// stream, tags each word with its byte address and flags bad immediates.
module rv32i_insn_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  input  logic             addr_load,
  input  logic [31:0]      addr_load_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_insn,
  output logic [31:0]      out_addr,
  output logic             out_err,
  output logic [CNT_W-1:0] insn_count,
  output logic [7:0]       err_count
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  fmt_e        w_fmt;
  logic [31:0] w_insn;
  logic        w_err;
  logic        w_hi11_ok;
  logic        w_hi12_ok;
  logic        w_hi20_ok;
  logic        w_accept;
  logic        w_handoff;
  logic [31:0] w_load_addr;
  logic [31:0] w_addr;

  logic             r_out_valid;
  logic [31:0]      r_out_insn;
  logic [31:0]      r_out_addr;
  logic             r_out_err;
  logic [31:0]      r_ptr;
  logic [CNT_W-1:0] r_insn_count;
  logic [7:0]       r_err_count;

  assign w_fmt = fmt_e'(in_fmt);

  // Sign-extension checks: the upper bits must all be copies of the field's top bit.
  assign w_hi11_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_hi12_ok = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign w_hi20_ok = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    w_insn = '0;
    w_err  = 1'b0;
    case (w_fmt)
      FMT_R: begin
        w_insn = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_I: begin
        w_insn = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_err  = ~w_hi11_ok;
      end
      FMT_ISH: begin
        w_insn = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_err  = |in_imm[31:5];
      end
      FMT_S: begin
        w_insn = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_err  = ~w_hi11_ok;
      end
      FMT_B: begin
        w_insn = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                  in_imm[4:1], in_imm[11], in_opcode};
        w_err  = ~w_hi12_ok | in_imm[0];
      end
      FMT_U: begin
        w_insn = {in_imm[31:12], in_rd, in_opcode};
        w_err  = |in_imm[11:0];
      end
      FMT_J: begin
        w_insn = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        w_err  = ~w_hi20_ok | in_imm[0];
      end
      default: begin
        w_insn = '0;
        w_err  = 1'b1;
      end
    endcase
  end

  assign in_ready    = ~r_out_valid | out_ready;
  assign w_accept    = in_valid & in_ready;
  assign w_handoff   = r_out_valid & out_ready;
  assign w_load_addr = addr_load_val & 32'hFFFF_FFFC;
  assign w_addr      = addr_load ? w_load_addr : r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_insn   <= '0;
      r_out_addr   <= '0;
      r_out_err    <= 1'b0;
      r_ptr        <= BASE_ADDR;
      r_insn_count <= '0;
      r_err_count  <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_insn  <= w_insn;
        r_out_addr  <= w_addr;
        r_out_err   <= w_err;
        r_ptr       <= w_addr + 32'd4;
      end else begin
        if (addr_load) r_ptr <= w_load_addr;
        if (w_handoff) r_out_valid <= 1'b0;
      end
      // Counters reflect the word leaving this cycle, not the one being loaded.
      if (w_handoff) begin
        r_insn_count <= r_insn_count + CNT_W'(1);
        if (r_out_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_insn   = r_out_insn;
  assign out_addr   = r_out_addr;
  assign out_err    = r_out_err;
  assign insn_count = r_insn_count;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_rv32i_insn_encoder.sv
// Scoreboard bench for rv32i_insn_encoder: driver pushes expected words from a field-level
// model, a negedge monitor compares whatever the encoder presents.
module tb_rv32i_insn_encoder;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          addr_load = 1'b0;
  logic [31:0]   addr_load_val = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_insn, out_addr;
  logic          out_err;
  logic [CW-1:0] insn_count;
  logic [7:0]    err_count;

  rv32i_insn_encoder #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_load(addr_load), .addr_load_val(addr_load_val), .out_valid(out_valid),
    .out_ready(out_ready), .out_insn(out_insn), .out_addr(out_addr), .out_err(out_err),
    .insn_count(insn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   npass = 0;
  int   ntot  = 0;

  bit          m_valid = 1'b0;
  bit          m_held_err = 1'b0;
  int unsigned m_cnt = 0;
  int unsigned m_errc = 0;
  logic [31:0] m_ptr = BASE;

  int          s_fmt;
  logic [31:0] s_op, s_rd, s_rs1, s_rs2, s_f3, s_f7, s_imm;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int w);
    return (v >> lo) & ((32'd1 << w) - 32'd1);
  endfunction

  // Reference: fields placed by shift-and-add, legality judged on the signed value.
  function automatic void model(input int fmt, input logic [31:0] op, rd, rs1, rs2, f3, f7, imm,
                                output logic [31:0] insn, output logic err);
    longint s;
    s = longint'($signed(imm));
    insn = 32'd0;
    err  = 1'b0;
    case (fmt)
      0: insn = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
      1: begin
        insn = (fld(imm, 0, 12) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
        err  = !(s >= -2048 && s <= 2047);
      end
      2: begin
        insn = (f7 << 25) + (fld(imm, 0, 5) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
        err  = imm > 32'd31;
      end
      3: begin
        insn = (fld(imm, 5, 7) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
             + (fld(imm, 0, 5) << 7) + op;
        err  = !(s >= -2048 && s <= 2047);
      end
      4: begin
        insn = (fld(imm, 12, 1) << 31) + (fld(imm, 5, 6) << 25) + (rs2 << 20) + (rs1 << 15)
             + (f3 << 12) + (fld(imm, 1, 4) << 8) + (fld(imm, 11, 1) << 7) + op;
        err  = !(s >= -4096 && s <= 4095) || (imm % 2 != 0);
      end
      5: begin
        insn = (imm / 4096) * 4096 + (rd << 7) + op;
        err  = (imm % 4096) != 0;
      end
      6: begin
        insn = (fld(imm, 20, 1) << 31) + (fld(imm, 1, 10) << 21) + (fld(imm, 11, 1) << 20)
             + (fld(imm, 12, 8) << 12) + (rd << 7) + op;
        err  = !(s >= -1048576 && s <= 1048575) || (imm % 2 != 0);
      end
      default: begin
        insn = 32'd0;
        err  = 1'b1;
      end
    endcase
  endfunction

  task automatic set_f(input int fmt, input int op, rd, rs1, rs2, f3, f7, input logic [31:0] imm);
    s_fmt = fmt; s_op = op; s_rd = rd; s_rs1 = rs1; s_rs2 = rs2;
    s_f3 = f3; s_f7 = f7; s_imm = imm;
  endtask

  // One clock cycle, entered just after a rising edge.
  task automatic step(input bit v, input bit ordy, input bit ld, input logic [31:0] ldv,
                      input bit use_lit, input logic [31:0] lit);
    bit          acc, hoff;
    logic [31:0] ei, a;
    logic        ee;
    #1;
    in_valid = v; out_ready = ordy; in_fmt = 3'(s_fmt); in_opcode = s_op[6:0];
    in_rd = s_rd[4:0]; in_rs1 = s_rs1[4:0]; in_rs2 = s_rs2[4:0]; in_funct3 = s_f3[2:0];
    in_funct7 = s_f7[6:0]; in_imm = s_imm; addr_load = ld; addr_load_val = ldv;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    chk("insn_count", 32'(insn_count), m_cnt % 65536);
    chk("err_count", 32'(err_count), m_errc);
    hoff = m_valid && ordy;
    acc  = v && (!m_valid || ordy);
    if (hoff) begin
      m_cnt++;
      if (m_held_err && m_errc < 255) m_errc++;
    end
    if (acc) begin
      model(s_fmt, s_op, s_rd, s_rs1, s_rs2, s_f3, s_f7, s_imm, ei, ee);
      if (use_lit) ei = lit;
      a = ld ? (ldv & ~32'd3) : m_ptr;
      q.push_back('{insn: ei, addr: a, err: ee});
      m_ptr = a + 32'd4;
      m_held_err = ee;
      m_valid = 1'b1;
    end else begin
      if (ld) m_ptr = ldv & ~32'd3;
      if (hoff) m_valid = 1'b0;
    end
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        ntot++;
        $display("FAIL scoreboard: unexpected word %h at %h, expected none", out_insn, out_addr);
      end else begin
        chk("out_insn", out_insn, q[0].insn);
        chk("out_addr", out_addr, q[0].addr);
        chk("out_err", 32'(out_err), 32'(q[0].err));
        if (out_ready) q.delete(0);
      end
    end
  end

  function automatic logic [31:0] rand_imm(input int fmt);
    logic [31:0] r;
    r = $urandom;
    if ($urandom % 4 != 0) begin
      case (fmt)
        1, 3: r = {{20{r[11]}}, r[11:0]};
        2: r = r % 32;
        4: r = {{19{r[12]}}, r[12:1], 1'b0};
        5: r = r & 32'hFFFF_F000;
        6: r = {{11{r[20]}}, r[20:1], 1'b0};
        default: ;
      endcase
    end
    return r;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_insn", out_insn, 0);
    chk("rst out_addr", out_addr, 0);
    chk("rst out_err", 32'(out_err), 0);
    chk("rst insn_count", 32'(insn_count), 0);
    chk("rst err_count", 32'(err_count), 0);
    rst_n = 1'b1;
    @(posedge clk);

    set_f(1, 'h13, 3, 3, 0, 0, 0, 32'd1311);      step(1, 1, 0, 0, 1, 32'h51f18193);
    set_f(2, 'h13, 18, 9, 0, 5, 'h20, 32'd12);    step(1, 1, 0, 0, 1, 32'h40c4d913);
    set_f(0, 'h33, 18, 4, 9, 1, 0, 0);            step(1, 1, 0, 0, 1, 32'h00921933);
    set_f(0, 'h33, 14, 3, 9, 5, 'h20, 0);         step(1, 1, 0, 0, 1, 32'h4091d733);
    set_f(4, 'h63, 0, 1, 2, 0, 0, -32'sd4);       step(1, 1, 0, 0, 1, 32'hfe208ee3);
    set_f(4, 'h63, 0, 1, 2, 0, 0, 32'd3);         step(1, 1, 0, 0, 0, 0);

    set_f(1, 'h13, 5, 6, 0, 0, 0, 32'd7);
    repeat (6) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);

    set_f(1, 'h13, 1, 2, 0, 0, 0, 32'd100);       step(1, 1, 1, 32'h0000_1003, 0, 0);
    step(1, 1, 0, 0, 0, 0);

    set_f(7, 0, 0, 0, 0, 0, 0, 0);
    repeat (260) step(1, 1, 0, 0, 0, 0);

    set_f(1, 'h13, 1, 1, 0, 0, 0, 0);             step(1, 1, 1, 32'hFFFF_FFFB, 0, 0);
    step(1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      int          f;
      logic [31:0] ldv;
      f = $urandom % 8;
      set_f(f, $urandom % 128, $urandom % 32, $urandom % 32, $urandom % 32,
            $urandom % 8, $urandom % 128, rand_imm(f));
      ldv = ($urandom % 2 != 0) ? $urandom : (32'hFFFF_FFF0 | ($urandom % 16));
      step($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 16 == 0, ldv, 0, 0);
    end
    repeat (3) step(0, 1, 0, 0, 0, 0);

    set_f(1, 'h13, 3, 3, 0, 0, 0, 32'd9);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst insn_count", 32'(insn_count), 0);
    chk("midrst err_count", 32'(err_count), 0);
    q.delete();
    m_valid = 1'b0; m_held_err = 1'b0; m_cnt = 0; m_errc = 0; m_ptr = BASE;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    step(0, 1, 0, 0, 0, 0);
    set_f(1, 'h13, 4, 4, 0, 0, 0, 32'd1);         step(1, 1, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0, 0);

    if (q.size() != 0) begin
      ntot++;
      $display("FAIL drain: %0d words left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
